// File: rtl/ql_beep_pkg.sv
// ql_beep_pkg: shared types and constants for the BEEP sound generator
package ql_beep_pkg;
  typedef enum logic {IDLE, PLAY} state_e;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int DUR_DIV_DEF = 9;
  localparam int PW = 8;
  localparam int GW = 16;
endpackage

// File: rtl/ql_lfsr16.sv
// ql_lfsr16: 16-bit Fibonacci LFSR, taps 16,14,13,11, reloadable to a seed
module ql_lfsr16 import ql_beep_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  output logic [15:0] q
);
  always_ff @(posedge clk) begin
    if (reset || load) q <= SEED;
    else if (en) q <= {q[14:0], ^(q & LFSR_TAPS)};
  end
endmodule

// File: rtl/ql_beep.sv
// ql_beep: IPC BEEP tone generator with sweep, wrap/bounce, fuzz and random modulation
module ql_beep import ql_beep_pkg::*; #(
  parameter int          DUR_DIV   = DUR_DIV_DEF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ce,
  input  logic          start,
  input  logic          stop,
  input  logic [15:0]   duration,
  input  logic [PW-1:0] pitch1,
  input  logic [PW-1:0] pitch2,
  input  logic [GW-1:0] grad_x,
  input  logic [3:0]    grad_y,
  input  logic [3:0]    wrap,
  input  logic [3:0]    fuzz,
  input  logic [3:0]    random,
  output logic          busy,
  output logic          audio
);
  localparam logic [15:0] DIV_LAST = 16'(DUR_DIV - 1);
  state_e        state_q;
  logic          audio_q, dur_inf_q;
  logic [PW-1:0] pitch1_q, pitch2_q, cur_pitch_q, cur_pitch_d;
  logic [GW-1:0] grad_x_q, step_cnt_q;
  logic [3:0]    grad_y_q, grad_y_d, wrap_q, wraps_left_q, wraps_left_d, fuzz_q, random_q;
  logic [PW:0]   half_cnt_q, half_cnt_d;
  logic [15:0]   dur_cnt_q, div_cnt_q, lfsr;
  logic [9:0]    next_p, lo, hi;
  logic          tick, toggle, sweep, div_wrap, dur_done, in_range;
  assign tick     = ce && state_q == PLAY && !start && !stop;
  assign toggle   = half_cnt_q == '0;
  assign sweep    = toggle && grad_x_q != '0 && step_cnt_q == 16'd1;
  assign div_wrap = div_cnt_q == '0;
  assign dur_done = div_wrap && !dur_inf_q && dur_cnt_q == 16'd1;
  assign half_cnt_d = toggle ? {1'b0, cur_pitch_q} + {5'b0, lfsr[3:0] & fuzz_q} : half_cnt_q - 1'b1;
  // 10-bit signed candidate: a negative result shows up as bit 9 set
  assign next_p   = {2'b0, cur_pitch_q} + {{6{grad_y_q[3]}}, grad_y_q} + {6'b0, lfsr[7:4] & random_q};
  assign lo       = {2'b0, (pitch1_q < pitch2_q) ? pitch1_q : pitch2_q};
  assign hi       = {2'b0, (pitch1_q < pitch2_q) ? pitch2_q : pitch1_q};
  assign in_range = !next_p[9] && next_p >= lo && next_p <= hi;
  assign cur_pitch_d  = in_range ? next_p[PW-1:0] : (wraps_left_q != '0) ? pitch1_q : cur_pitch_q;
  assign wraps_left_d = in_range ? wraps_left_q : (wraps_left_q != '0) ? wraps_left_q - 1'b1 : wrap_q;
  assign grad_y_d     = (in_range || wraps_left_q != '0) ? grad_y_q : (grad_y_q == 4'h8) ? 4'h7 : -grad_y_q;
  ql_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk_sys),
    .reset (reset),
    .en    (tick),
    .load  (lfsr == '0),
    .q     (lfsr)
  );
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      audio_q      <= 1'b0;
      dur_inf_q    <= 1'b0;
      pitch1_q     <= '0;
      pitch2_q     <= '0;
      cur_pitch_q  <= '0;
      grad_x_q     <= '0;
      step_cnt_q   <= '0;
      grad_y_q     <= '0;
      wrap_q       <= '0;
      wraps_left_q <= '0;
      fuzz_q       <= '0;
      random_q     <= '0;
      half_cnt_q   <= '0;
      dur_cnt_q    <= '0;
      div_cnt_q    <= '0;
    end else if (start) begin
      state_q      <= PLAY;
      audio_q      <= 1'b0;
      dur_inf_q    <= duration == '0;
      pitch1_q     <= pitch1;
      pitch2_q     <= pitch2;
      cur_pitch_q  <= pitch1;
      grad_x_q     <= grad_x;
      step_cnt_q   <= grad_x;
      grad_y_q     <= grad_y;
      wrap_q       <= wrap;
      wraps_left_q <= wrap;
      fuzz_q       <= fuzz;
      random_q     <= random;
      half_cnt_q   <= {1'b0, pitch1};
      dur_cnt_q    <= duration;
      div_cnt_q    <= DIV_LAST;
    end else if (stop || state_q == IDLE) begin
      state_q <= IDLE;
      audio_q <= 1'b0;
    end else if (ce) begin
      half_cnt_q <= half_cnt_d;
      audio_q    <= dur_done ? 1'b0 : audio_q ^ toggle;
      div_cnt_q  <= div_wrap ? DIV_LAST : div_cnt_q - 1'b1;
      if (toggle && grad_x_q != '0) step_cnt_q <= sweep ? grad_x_q : step_cnt_q - 1'b1;
      if (sweep) begin
        cur_pitch_q  <= cur_pitch_d;
        wraps_left_q <= wraps_left_d;
        grad_y_q     <= grad_y_d;
      end
      if (div_wrap && !dur_inf_q) dur_cnt_q <= dur_cnt_q - 1'b1;
      if (dur_done) state_q <= IDLE;
    end
  end
  assign busy  = state_q == PLAY;
  assign audio = audio_q;
endmodule

// File: tb/tb_ql_beep.sv
// tb_ql_beep: directed self-checking bench for the BEEP tone generator
module tb_ql_beep;
  logic        clk_sys = 1'b0;
  logic        reset, ce, start, stop, busy, audio;
  logic [15:0] duration, grad_x;
  logic [7:0]  pitch1, pitch2;
  logic [3:0]  grad_y, wrap, fuzz, random;
  logic [15:0] mdl, mdl_tog;
  int          checks = 0, errs = 0;
  int          n, tog, want;
  logic        a0;
  int          sw[16] = '{3, 3, 4, 5, 6, 3, 4, 5, 6, 6, 5, 4, 3, 3, 3, 4};

  always #5 clk_sys = ~clk_sys;

  ql_beep #(.DUR_DIV(9), .LFSR_SEED(16'hACE1)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce       (ce),
    .start    (start),
    .stop     (stop),
    .duration (duration),
    .pitch1   (pitch1),
    .pitch2   (pitch2),
    .grad_x   (grad_x),
    .grad_y   (grad_y),
    .wrap     (wrap),
    .fuzz     (fuzz),
    .random   (random),
    .busy     (busy),
    .audio    (audio)
  );

  task automatic cycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] need);
    checks++;
    assert (got === need) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, need);
    end
  endtask

  task automatic setp(input logic [7:0] p1, input logic [7:0] p2, input logic [15:0] gx,
                      input logic [3:0] gy, input logic [3:0] w, input logic [3:0] f,
                      input logic [3:0] r, input logic [15:0] d);
    pitch1 = p1; pitch2 = p2; grad_x = gx; grad_y = gy;
    wrap = w; fuzz = f; random = r; duration = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    ce = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // counts ce ticks until audio changes, tracking the reference LFSR alongside
  task automatic wait_toggle(output int cnt);
    logic start_lvl;
    start_lvl = audio;
    cnt = 0;
    do begin
      mdl_tog = mdl;
      ce = 1'b1;
      cycle();
      mdl = ref_lfsr(mdl);
      cnt++;
    end while (audio === start_lvl && cnt < 64);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ce = 1'b0; start = 1'b0; stop = 1'b0;
    setp(0, 0, 0, 0, 0, 0, 0, 0);
    mdl = 16'hACE1;
    cycle();
    cycle();
    chk("reset_busy", busy, 0);
    chk("reset_audio", audio, 0);
    chk("reset_lfsr", dut.lfsr, 16'hACE1);
    reset = 1'b0;

    // basic tone: pitch 3, two duration units of 9 ticks
    setp(3, 0, 0, 0, 0, 0, 0, 2);
    do_start();
    chk("tone_busy0", busy, 1);
    chk("tone_audio0", audio, 0);
    ce = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      cycle();
      chk($sformatf("tone_audio_ce%0d", k), audio, (k < 18) ? ((k / 4) & 1) : 0);
      chk($sformatf("tone_busy_ce%0d", k), busy, (k < 18) ? 1 : 0);
    end

    // infinite play at pitch 0, then stop
    setp(0, 0, 0, 0, 0, 0, 0, 0);
    do_start();
    tog = 0;
    for (int k = 1; k <= 1001; k++) begin
      a0 = audio;
      cycle();
      if (audio !== a0) tog++;
    end
    chk("inf_toggles", tog, 1001);
    chk("inf_audio", audio, 1);
    chk("inf_busy", busy, 1);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_audio", audio, 0);
    cycle();
    chk("idle_busy", busy, 0);
    chk("idle_audio", audio, 0);

    // up-sweep 2..5 with one wrap, then bounce down and bounce again
    setp(2, 5, 1, 4'h1, 1, 0, 0, 0);
    do_start();
    for (int i = 0; i < 16; i++) begin
      wait_toggle(n);
      chk($sformatf("sweep_half%0d", i), n, sw[i]);
    end
    stop = 1'b1;
    cycle();
    stop = 1'b0;

    // restart mid-play; ce coinciding with start is ignored
    setp(10, 0, 0, 0, 0, 0, 0, 0);
    do_start();
    ce = 1'b1;
    for (int k = 1; k <= 4; k++) cycle();
    chk("rst_pre_audio", audio, 0);
    setp(1, 0, 0, 0, 0, 0, 0, 0);
    do_start();
    chk("rst_busy", busy, 1);
    chk("rst_audio0", audio, 0);
    cycle();
    chk("rst_audio1", audio, 0);
    cycle();
    chk("rst_audio2", audio, 1);
    start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 1);
    chk("startstop_audio", audio, 0);
    stop = 1'b1;
    cycle();
    stop = 1'b0;

    // fuzz against a reference LFSR, from a freshly seeded generator
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    setp(0, 0, 0, 0, 0, 4'hF, 0, 0);
    do_start();
    mdl = 16'hACE1;
    want = 1;
    for (int i = 0; i < 10; i++) begin
      wait_toggle(n);
      chk($sformatf("fuzz_half%0d", i), n, want);
      want = int'(mdl_tog[3:0]) + 1;
    end
    setp(0, 0, 0, 0, 0, 4'h0, 0, 0);
    do_start();
    for (int i = 0; i < 5; i++) begin
      wait_toggle(n);
      chk($sformatf("nofuzz_half%0d", i), n, 1);
    end

    // reset during play
    setp(0, 0, 0, 0, 0, 0, 0, 0);
    do_start();
    for (int k = 1; k <= 3; k++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rstplay_busy", busy, 0);
    chk("rstplay_audio", audio, 0);
    chk("rstplay_lfsr", dut.lfsr, 16'hACE1);
    cycle();
    chk("rstplay_busy_next", busy, 0);
    chk("rstplay_audio_next", audio, 0);
    chk("rstplay_lfsr_next", dut.lfsr, 16'hACE1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
